// File: rtl/hd44780_lcd_top.sv
// HD44780 character-LCD controller, 4-bit interface, write-only.
// After reset it waits for LCD power-up, runs the 4-bit init handshake,
// configures the display, writes "HELLO WORLD" to line 1 and then idles.
module hd44780_lcd_top #(
  parameter int unsigned T_POWERUP = 1500000,
  parameter int unsigned T_INIT1   = 410000,
  parameter int unsigned T_INIT2   = 10000,
  parameter int unsigned T_SETUP   = 4,
  parameter int unsigned T_EN_HIGH = 50,
  parameter int unsigned T_HOLD    = 100,
  parameter int unsigned T_CMD     = 5000,
  parameter int unsigned T_CLEAR   = 200000
) (
  input  logic       clk,
  input  logic       rst,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [3:0] lcd_data
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Delay counter must hold the longest wait minus one.
  localparam int unsigned DLY_MAX = max2(max2(max2(T_POWERUP, T_INIT1), max2(T_INIT2, T_CMD)),
                                         max2(T_CLEAR, max2(T_SETUP, max2(T_EN_HIGH, T_HOLD))));
  localparam int DLY_W = $clog2(DLY_MAX + 1);

  typedef enum logic [2:0] {
    S_POWERUP,
    S_NIB_SETUP,
    S_NIB_EN,
    S_NIB_HOLD,
    S_WAIT,
    S_DONE
  } state_t;

  // Which part of the power-on script is being sent.
  typedef enum logic [1:0] {
    PH_INIT,  // single-nibble 0x3,0x3,0x3,0x2 handshake
    PH_CMD,   // configuration command bytes
    PH_MSG    // message data bytes
  } phase_t;

  localparam logic [3:0] MSG_LEN = 4'd11;

  // Byte (or, in the init phase, nibble in bits 3:0) for a given script item.
  function automatic logic [7:0] item_byte(input phase_t ph, input logic [3:0] i);
    logic [7:0] b;
    b = 8'h00;
    case (ph)
      PH_INIT: b = (i == 4'd3) ? 8'h02 : 8'h03;
      PH_CMD: begin
        case (i)
          4'd0:    b = 8'h28;  // 4-bit, 2 lines, 5x8 font
          4'd1:    b = 8'h0C;  // display on, cursor off
          4'd2:    b = 8'h01;  // clear display
          4'd3:    b = 8'h06;  // increment, no shift
          default: b = 8'h80;  // DDRAM address 0
        endcase
      end
      default: begin
        case (i)
          4'd0:    b = 8'h48;  // H
          4'd1:    b = 8'h45;  // E
          4'd2:    b = 8'h4C;  // L
          4'd3:    b = 8'h4C;  // L
          4'd4:    b = 8'h4F;  // O
          4'd5:    b = 8'h20;  // space
          4'd6:    b = 8'h57;  // W
          4'd7:    b = 8'h4F;  // O
          4'd8:    b = 8'h52;  // R
          4'd9:    b = 8'h4C;  // L
          4'd10:   b = 8'h44;  // D
          default: b = 8'h20;
        endcase
      end
    endcase
    return b;
  endfunction

  // First nibble put on the bus for an item: the lone nibble during init,
  // otherwise the high nibble of the byte.
  function automatic logic [3:0] first_nib(input phase_t ph, input logic [7:0] b);
    return (ph == PH_INIT) ? b[3:0] : b[7:4];
  endfunction

  state_t           state;
  phase_t           phase;
  logic [3:0]       idx;
  logic             low_nib;
  logic [DLY_W-1:0] cnt;

  phase_t           nxt_phase;
  logic [3:0]       nxt_idx;
  logic             nxt_done;
  logic [7:0]       cur_byte;
  logic [7:0]       nxt_byte;
  logic [DLY_W-1:0] wait_load;

  assign lcd_rw = 1'b0;

  // Current item, the item that follows it, and the wait owed after the current item.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cur_byte  = item_byte(phase, idx);
    nxt_phase = phase;
    nxt_idx   = idx + 4'd1;
    nxt_done  = 1'b0;
    case (phase)
      PH_INIT: if (idx == 4'd3) begin nxt_phase = PH_CMD; nxt_idx = 4'd0; end
      PH_CMD:  if (idx == 4'd4) begin nxt_phase = PH_MSG; nxt_idx = 4'd0; end
      default: if (nxt_idx == MSG_LEN) nxt_done = 1'b1;
    endcase
    nxt_byte = item_byte(nxt_phase, nxt_idx);

    if (phase == PH_INIT)
      wait_load = (idx == 4'd0) ? DLY_W'(T_INIT1 - 1) : DLY_W'(T_INIT2 - 1);
    else if (phase == PH_CMD && cur_byte == 8'h01)
      wait_load = DLY_W'(T_CLEAR - 1);
    else
      wait_load = DLY_W'(T_CMD - 1);
  end

  // Sequencer: every state lasts exactly its loaded count + 1 cycles; pins are registered here.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_POWERUP;
      phase    <= PH_INIT;
      idx      <= 4'd0;
      low_nib  <= 1'b0;
      cnt      <= DLY_W'(T_POWERUP - 1);
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_data <= 4'h0;
    end else begin
      case (state)
        S_POWERUP: begin
          if (cnt == '0) begin
            state    <= S_NIB_SETUP;
            cnt      <= DLY_W'(T_SETUP - 1);
            lcd_rs   <= 1'b0;
            lcd_data <= first_nib(phase, cur_byte);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_NIB_SETUP: begin
          if (cnt == '0) begin
            state  <= S_NIB_EN;
            cnt    <= DLY_W'(T_EN_HIGH - 1);
            lcd_en <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_NIB_EN: begin
          if (cnt == '0) begin
            state  <= S_NIB_HOLD;
            cnt    <= DLY_W'(T_HOLD - 1);
            lcd_en <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_NIB_HOLD: begin
          if (cnt == '0) begin
            if (phase != PH_INIT && !low_nib) begin
              // Second half of a byte: same rs, low nibble.
              state    <= S_NIB_SETUP;
              cnt      <= DLY_W'(T_SETUP - 1);
              low_nib  <= 1'b1;
              lcd_data <= cur_byte[3:0];
            end else begin
              state <= S_WAIT;
              cnt   <= wait_load;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            phase   <= nxt_phase;
            idx     <= nxt_idx;
            low_nib <= 1'b0;
            if (nxt_done) begin
              state    <= S_DONE;
              lcd_rs   <= 1'b0;
              lcd_data <= 4'h0;
            end else begin
              state    <= S_NIB_SETUP;
              cnt      <= DLY_W'(T_SETUP - 1);
              lcd_rs   <= (nxt_phase == PH_MSG);
              lcd_data <= first_nib(nxt_phase, nxt_byte);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state    <= S_DONE;
          lcd_rs   <= 1'b0;
          lcd_en   <= 1'b0;
          lcd_data <= 4'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hd44780_lcd_top.sv
// Bench for hd44780_lcd_top with scaled timing parameters.
// A sampler records every enable strobe and checks bus protocol each cycle;
// scenario tasks compare the recorded strobes with a model of the power-on script.
module tb_hd44780_lcd_top;

  localparam int unsigned T_POWERUP = 100;
  localparam int unsigned T_INIT1   = 40;
  localparam int unsigned T_INIT2   = 10;
  localparam int unsigned T_SETUP   = 2;
  localparam int unsigned T_EN_HIGH = 5;
  localparam int unsigned T_HOLD    = 3;
  localparam int unsigned T_CMD     = 20;
  localparam int unsigned T_CLEAR   = 50;
  localparam int          BUDGET    = 5000;

  logic       clk;
  logic       rst;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [3:0] lcd_data;

  hd44780_lcd_top #(
    .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_SETUP(T_SETUP),
    .T_EN_HIGH(T_EN_HIGH), .T_HOLD(T_HOLD), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR)
  ) dut (
    .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // One observed strobe: bus value latched at the falling edge, high width, low gap before rise.
  typedef struct {
    logic       rs;
    logic [3:0] nib;
    int         hi;
    int         gap;
  } strobe_t;

  strobe_t strobes[$];

  // Reference model of the script: nibble list with the wait owed after each nibble,
  // and the byte list (commands then message).
  logic       exp_rs[$];
  logic [3:0] exp_nib[$];
  int         exp_wait[$];
  logic [7:0] exp_byte[$];
  logic       exp_byte_rs[$];

  task automatic add_byte(input logic r, input logic [7:0] b);
    exp_byte.push_back(b);
    exp_byte_rs.push_back(r);
    exp_rs.push_back(r);  exp_nib.push_back(b[7:4]); exp_wait.push_back(0);
    exp_rs.push_back(r);  exp_nib.push_back(b[3:0]);
    exp_wait.push_back((!r && b == 8'h01) ? int'(T_CLEAR) : int'(T_CMD));
  endtask

  task automatic build_model();
    logic [7:0] cmds [5];
    logic [3:0] inits [4];
    int         iwait [4];
    string      msg;
    cmds  = '{8'h28, 8'h0C, 8'h01, 8'h06, 8'h80};
    inits = '{4'h3, 4'h3, 4'h3, 4'h2};
    iwait = '{int'(T_INIT1), int'(T_INIT2), int'(T_INIT2), int'(T_INIT2)};
    msg   = "HELLO WORLD";
    for (int i = 0; i < 4; i++) begin
      exp_rs.push_back(1'b0); exp_nib.push_back(inits[i]); exp_wait.push_back(iwait[i]);
    end
    for (int i = 0; i < 5; i++) add_byte(1'b0, cmds[i]);
    for (int i = 0; i < msg.len(); i++) add_byte(1'b1, msg[i]);
  endtask

  // Sampler and protocol checker, one sample 1 time unit after each rising edge.
  logic       prev_en;
  logic [4:0] prev_bus;
  int         stable_cnt, hi_cnt, lo_cnt, gap_at_rise;

  always @(posedge clk) begin
    logic [4:0] bus;
    #1;
    n_checks++;
    if (lcd_rw !== 1'b0) $display("FAIL rw_low: lcd_rw=%b expected 0 at %0t", lcd_rw, $time);
    else n_pass++;
    bus = {lcd_rs, lcd_data};
    if (rst !== 1'b1) begin
      prev_en = 1'b0; prev_bus = 5'h0; stable_cnt = 0; hi_cnt = 0; lo_cnt = 0; gap_at_rise = 0;
    end else begin
      if (prev_en) begin
        n_checks++;
        if (bus !== prev_bus) $display("FAIL bus_stable_en: {rs,data}=%h expected %h at %0t", bus, prev_bus, $time);
        else n_pass++;
      end
      if (lcd_en && !prev_en) begin
        n_checks++;
        if (stable_cnt < int'(T_SETUP)) $display("FAIL setup_time: stable %0d cycles expected >= %0d at %0t", stable_cnt, T_SETUP, $time);
        else n_pass++;
        gap_at_rise = lo_cnt;
        hi_cnt = 1;
      end else if (lcd_en) begin
        hi_cnt++;
      end else if (prev_en) begin
        strobes.push_back('{rs: prev_bus[4], nib: prev_bus[3:0], hi: hi_cnt, gap: gap_at_rise});
        lo_cnt = 1;
      end else begin
        lo_cnt++;
      end
      stable_cnt = (bus === prev_bus) ? stable_cnt + 1 : 1;
      prev_en  = lcd_en;
      prev_bus = bus;
    end
  end

  task automatic wait_for_strobes(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(posedge clk); #2;
      if (strobes.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  // Release reset just after a rising edge and check the power-up quiet period.
  task automatic release_and_check_powerup(input string tag);
    bit quiet;
    quiet = 1'b1;
    @(posedge clk); #1;
    strobes.delete();
    rst = 1'b1;
    for (int k = 1; k < int'(T_POWERUP); k++) begin
      @(posedge clk); #1;
      if (lcd_en !== 1'b0 || lcd_rs !== 1'b0 || lcd_data !== 4'h0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) $display("FAIL %s_powerup_quiet: bus active before %0d cycles", tag, T_POWERUP);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({lcd_en, lcd_rs, lcd_data} !== 6'b00_0011)
      $display("FAIL %s_powerup_end: {en,rs,data}=%b expected 000011", tag, {lcd_en, lcd_rs, lcd_data});
    else n_pass++;
  endtask

  task automatic test_reset();
    int hold;
    rst  = 1'b0;
    hold = 10 + int'($urandom_range(0, 6));
    repeat (hold) @(posedge clk);
    #1;
    n_checks++;
    if ({lcd_en, lcd_rs, lcd_rw, lcd_data} !== 7'h00)
      $display("FAIL reset_outputs: {en,rs,rw,data}=%b expected 0000000", {lcd_en, lcd_rs, lcd_rw, lcd_data});
    else n_pass++;
    release_and_check_powerup("reset");
  endtask

  task automatic test_init_nibbles();
    bit ok;
    wait_for_strobes(4, ok);
    n_checks++;
    if (!ok) begin $display("FAIL init_timeout: got %0d strobes expected 4", strobes.size()); return; end
    n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (strobes[k].rs !== exp_rs[k] || strobes[k].nib !== exp_nib[k])
        $display("FAIL init_nib%0d: rs=%b data=%h expected rs=%b data=%h", k, strobes[k].rs, strobes[k].nib, exp_rs[k], exp_nib[k]);
      else n_pass++;
      n_checks++;
      if (strobes[k].hi != int'(T_EN_HIGH)) $display("FAIL init_en_width%0d: %0d expected %0d", k, strobes[k].hi, T_EN_HIGH);
      else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (strobes[k].gap != int'(T_HOLD) + exp_wait[k-1] + int'(T_SETUP))
          $display("FAIL init_gap%0d: %0d expected %0d", k, strobes[k].gap, int'(T_HOLD) + exp_wait[k-1] + int'(T_SETUP));
        else n_pass++;
      end
    end
  endtask

  task automatic test_cmd_bytes();
    bit ok;
    logic [7:0] got;
    wait_for_strobes(14, ok);
    n_checks++;
    if (!ok) begin $display("FAIL cmd_timeout: got %0d strobes expected 14", strobes.size()); return; end
    n_pass++;
    for (int j = 0; j < 5; j++) begin
      got = {strobes[4+2*j].nib, strobes[5+2*j].nib};
      n_checks++;
      if (got !== exp_byte[j] || strobes[4+2*j].rs !== 1'b0 || strobes[5+2*j].rs !== 1'b0)
        $display("FAIL cmd_byte%0d: byte=%h rs=%b%b expected byte=%h rs=00", j, got, strobes[4+2*j].rs, strobes[5+2*j].rs, exp_byte[j]);
      else n_pass++;
    end
    for (int k = 4; k < 14; k++) begin
      n_checks++;
      if (strobes[k].hi != int'(T_EN_HIGH)) $display("FAIL cmd_en_width%0d: %0d expected %0d", k, strobes[k].hi, T_EN_HIGH);
      else n_pass++;
      n_checks++;
      if (strobes[k].gap - int'(T_HOLD) - int'(T_SETUP) != exp_wait[k-1])
        $display("FAIL cmd_wait%0d: %0d expected %0d", k, strobes[k].gap - int'(T_HOLD) - int'(T_SETUP), exp_wait[k-1]);
      else n_pass++;
    end
  endtask

  task automatic test_message();
    bit ok;
    logic [7:0] got;
    wait_for_strobes(36, ok);
    n_checks++;
    if (!ok) begin $display("FAIL msg_timeout: got %0d strobes expected 36", strobes.size()); return; end
    n_pass++;
    for (int j = 0; j < 11; j++) begin
      got = {strobes[14+2*j].nib, strobes[15+2*j].nib};
      n_checks++;
      if (got !== exp_byte[5+j] || strobes[14+2*j].rs !== 1'b1 || strobes[15+2*j].rs !== 1'b1)
        $display("FAIL msg_char%0d: byte=%h rs=%b%b expected byte=%h rs=11", j, got, strobes[14+2*j].rs, strobes[15+2*j].rs, exp_byte[5+j]);
      else n_pass++;
    end
    for (int k = 14; k < 36; k++) begin
      n_checks++;
      if (strobes[k].hi != int'(T_EN_HIGH) || strobes[k].gap != int'(T_HOLD) + exp_wait[k-1] + int'(T_SETUP))
        $display("FAIL msg_timing%0d: hi=%0d gap=%0d expected hi=%0d gap=%0d", k, strobes[k].hi, strobes[k].gap,
                 T_EN_HIGH, int'(T_HOLD) + exp_wait[k-1] + int'(T_SETUP));
      else n_pass++;
    end
  endtask

  task automatic test_idle();
    bit en_seen;
    en_seen = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      if (lcd_en !== 1'b0) en_seen = 1'b1;
    end
    n_checks++;
    if (en_seen || strobes.size() != exp_nib.size())
      $display("FAIL idle_quiet: en_seen=%b strobes=%0d expected en_seen=0 strobes=%0d", en_seen, strobes.size(), exp_nib.size());
    else n_pass++;
    n_checks++;
    if ({lcd_en, lcd_rs, lcd_data} !== 6'h00) $display("FAIL idle_bus: {en,rs,data}=%b expected 000000", {lcd_en, lcd_rs, lcd_data});
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int  target;
    bit  found;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    release_and_check_powerup("restart");
    target = 6 + int'($urandom_range(0, 1));  // high or low nibble of 0x0C
    found  = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(posedge clk); #1;
      if (strobes.size() == target && lcd_en === 1'b1) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin $display("FAIL midrst_find_en: strobe %0d with en=1 not seen", target); return; end
    n_pass++;
    #($urandom_range(1, 3));
    rst = 1'b0;
    #1;
    n_checks++;
    if ({lcd_en, lcd_rs, lcd_data} !== 6'h00)
      $display("FAIL midrst_async: {en,rs,data}=%b expected 000000", {lcd_en, lcd_rs, lcd_data});
    else n_pass++;
    repeat (int'($urandom_range(2, 6))) @(posedge clk);
    release_and_check_powerup("midrst");
  endtask

  initial begin
    rst = 1'b0;
    build_model();
    test_reset();
    test_init_nibbles();
    test_cmd_bytes();
    test_message();
    test_idle();
    test_mid_reset();
    test_init_nibbles();
    test_cmd_bytes();
    test_message();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
